piano_voice: RTL and testbench
==============================

# piano_voice

Parametrised multi-key square-wave tone generator for the piano datapath. Debounces `N_KEYS` key/light inputs, selects one sounding key by fixed priority and drives a single speaker pin with that key's tone; replaces the per-note sound blocks with one shared voice.

## Interface
- `N_KEYS`, 8: number of key inputs, 1..16.
- `DIV_W`, 32: width of half-period values and tone counter.
- `DEBOUNCE`, 3: consecutive cycles a key level must hold before it is accepted, 1..15.
- `HALF_PER`, C4..C5 at 50 MHz (95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778): packed `N_KEYS*DIV_W` vector, entry i at bits `[i*DIV_W +: DIV_W]`, half-period in clocks for key i; 0 is treated as 1.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `light` input `N_KEYS`: raw key levels, already synchronous to `clk`, 1 = pressed.
- `speaker` output 1: square-wave tone.
- `active` output 1: a key is sounding.
- `note_idx` output `max(1,$clog2(N_KEYS))`: index of sounding key, held at last value when idle.

## Operation
- Per-key debouncer: accepted level `deb[i]` plus run counter. If `light[i] != deb[i]`, increment; when `light[i]` has differed on `DEBOUNCE` consecutive sampled edges, `deb[i]` flips and counter clears. Any sample equal to `deb[i]` clears the counter.
- Selection (combinational from `deb`): lowest index with `deb[i]=1` wins; `sel_valid` = OR of `deb`.
- Voice FSM, states IDLE, PLAY:
  - IDLE: `speaker=0`, `active=0`, counter 0. If `sel_valid`: go PLAY; load counter with `HALF_PER[sel]-1`, set `speaker=1`, `note_idx=sel`, `active=1`.
  - PLAY, `sel_valid=0`: go IDLE; `speaker=0`, `active=0`, counter 0.
  - PLAY, `sel != note_idx`: stay PLAY; `note_idx=sel`, counter reloads `HALF_PER[sel]-1`, `speaker` toggles (new note starts on an edge, no glitch shorter than one clock).
  - PLAY, same key: counter 0 -> reload `HALF_PER[note_idx]-1` and toggle `speaker`; else decrement.
- Tone period = `2*HALF_PER[i]` clocks, 50 % duty.
- Counter arithmetic modulo `2^DIV_W`; all-ones half-period is legal.

## Timing
- Reset: `speaker=0`, `active=0`, `note_idx=0`, all `deb=0`, all debounce counters 0, counter 0, state IDLE. Reset mid-note silences `speaker` at the reset edge; dominates all inputs.
- Press latency: `light[i]` high first sampled at edge k, held -> `deb[i]=1` after edge k+DEBOUNCE-1 -> `speaker`/`active` rise after edge k+DEBOUNCE.
- Release latency identical: `speaker`, `active` low after edge k+DEBOUNCE from first low sample.
- Pulse shorter than `DEBOUNCE` cycles: no effect on `deb` or outputs.
- Higher-priority key accepted while lower sounds: switch on the edge after its `deb` rises; on its release, revert to lower key with fresh reload.
- Simultaneous acceptance of several keys: lowest index sounds.
- Release and press of different keys accepted on same edge: direct note change, no IDLE cycle.

## Configuration
- `PIANO_OCTAVE_EN` defined: adds input `octave_up` (1 bit); at every reload the half-period used is `HALF_PER[i] >> 1` (0 treated as 1) when `octave_up=1`, sampled at reload only, so changes take effect at the next toggle.
- Undefined: no `octave_up` port; full `HALF_PER[i]` always used.

## Test plan
Bench parameters: `N_KEYS=4`, `DEBOUNCE=3`, `HALF_PER={7,6,5,4}` (key0=4 … key3=7).
- Reset with `light=4'b1111` held -> `speaker=0`, `active=0`, `note_idx=0` during and 1 cycle after reset; outputs go active 3 cycles after reset release with `note_idx=0`.
- `light[2]` high from edge k -> `speaker` rises after edge k+3, toggles every 6 clocks, `note_idx=2`; released -> `speaker=0`, `active=0` 3 edges after first low sample.
- 2-cycle glitch on `light[1]` -> outputs unchanged, `deb[1]` stays 0.
- Key3 sounding, key0 pressed -> after key0 accepted, `note_idx=0`, `speaker` toggles, then every 4 clocks; key0 released -> back to key3, period 14 clocks.
- Key1 and key3 accepted same edge -> `note_idx=1`, period 10.
- With `PIANO_OCTAVE_EN`, key2, `octave_up=1` -> half-period 3 from next reload; `HALF_PER` entry 1 with `octave_up` -> toggles every clock.

Source files
------------

// File: rtl/piano_voice.sv
// Multi-key square-wave voice: per-key debounce, fixed-priority key select, one tone counter.
// Optional PIANO_OCTAVE_EN adds an octave_up input that halves the half-period at each reload.
module piano_voice #(
  parameter int N_KEYS   = 8,
  parameter int DIV_W    = 32,
  parameter int DEBOUNCE = 3,
  parameter logic [N_KEYS*DIV_W-1:0] HALF_PER = {
    32'd47778, 32'd50619, 32'd56818, 32'd63776,
    32'd71586, 32'd75843, 32'd85131, 32'd95556},
  localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PIANO_OCTAVE_EN
  input  logic              octave_up,
`endif
  input  logic [N_KEYS-1:0] light,
  output logic              speaker,
  output logic              active,
  output logic [IDX_W-1:0]  note_idx
);

  typedef enum logic {IDLE, PLAY} state_t;

  logic [N_KEYS-1:0] deb;
  logic [IDX_W-1:0]  sel;
  logic              sel_valid;
  logic              oct;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              spk_q, spk_d;
  logic [IDX_W-1:0]  note_q, note_d;

`ifdef PIANO_OCTAVE_EN
  assign oct = octave_up;
`else
  assign oct = 1'b0;
`endif

  // A key level is accepted only after it has differed from the accepted level
  // on DEBOUNCE consecutive edges; any agreeing sample restarts the run.
  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_deb
      logic       deb_bit_q;
      logic [3:0] run_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          deb_bit_q <= 1'b0;
          run_q     <= 4'd0;
        end else if (light[gi] != deb_bit_q) begin
          if (run_q == 4'(DEBOUNCE - 1)) begin
            deb_bit_q <= ~deb_bit_q;
            run_q     <= 4'd0;
          end else begin
            run_q <= run_q + 4'd1;
          end
        end else begin
          run_q <= 4'd0;
        end
      end
      assign deb[gi] = deb_bit_q;
    end
  endgenerate

  always_comb begin
    sel       = '0;
    sel_valid = |deb;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (deb[i]) sel = IDX_W'(i);
    end
  end

  // Counter preset for a key: half-period minus one, zero half-periods act as one.
  function automatic logic [DIV_W-1:0] reload_val(input logic [IDX_W-1:0] idx,
                                                  input logic             half);
    logic [DIV_W-1:0] hp;
    hp = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (idx == IDX_W'(i)) hp = HALF_PER[i*DIV_W +: DIV_W];
    end
    if (half) hp = hp >> 1;
    if (hp == '0) hp = DIV_W'(1);
    return hp - DIV_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      spk_q   <= 1'b0;
      note_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spk_q   <= spk_d;
      note_q  <= note_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    spk_d   = spk_q;
    note_d  = note_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        spk_d = 1'b0;
        if (sel_valid) begin
          state_d = PLAY;
          cnt_d   = reload_val(sel, oct);
          spk_d   = 1'b1;
          note_d  = sel;
        end
      end
      PLAY: begin
        if (!sel_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
          spk_d   = 1'b0;
        end else if (sel != note_q) begin
          // Note change starts on an edge so no short pulse is emitted.
          note_d = sel;
          cnt_d  = reload_val(sel, oct);
          spk_d  = ~spk_q;
        end else if (cnt_q == '0) begin
          cnt_d = reload_val(note_q, oct);
          spk_d = ~spk_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign speaker  = spk_q;
  assign active   = (state_q == PLAY);
  assign note_idx = note_q;

endmodule

// File: tb/tb_piano_voice.sv
// Self-checking bench for piano_voice: directed scenarios plus random key activity
// compared against a behavioural model built from key hold times and elapsed note time.
module tb_piano_voice;
  localparam int NK = 4;
  localparam int DW = 8;
  localparam int DB = 3;
  localparam logic [NK*DW-1:0] HP = {8'd7, 8'd6, 8'd5, 8'd4};

  int hp_tab [NK] = '{4, 5, 6, 7};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] light = '0;
  logic          speaker;
  logic          active;
  logic [1:0]    note_idx;
`ifdef PIANO_OCTAVE_EN
  logic          octave_up = 1'b0;
`endif

  piano_voice #(.N_KEYS(NK), .DIV_W(DW), .DEBOUNCE(DB), .HALF_PER(HP)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef PIANO_OCTAVE_EN
    .octave_up(octave_up),
`endif
    .light    (light),
    .speaker  (speaker),
    .active   (active),
    .note_idx (note_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;
  int step_no = 0;

  // Model state: accepted levels, recent samples, and the note being played.
  logic [NK-1:0] m_deb;
  logic [DB-1:0] m_hist [NK];
  bit            m_sounding;
  int            m_note;
  bit            m_start;
  int            m_n;

  function automatic bit model_spk();
    if (!m_sounding) return 1'b0;
    return m_start ^ bit'((m_n / hp_tab[m_note]) % 2);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s step %0d: got %0d expected %0d", tag, step_no, got, exp);
    end
  endtask

  task automatic model_edge();
    int  sel;
    bit  valid;
    bit  cur;
    if (rst) begin
      m_deb      = '0;
      for (int k = 0; k < NK; k++) m_hist[k] = '0;
      m_sounding = 0;
      m_note     = 0;
      m_start    = 0;
      m_n        = 0;
      return;
    end
    valid = 0;
    sel   = 0;
    for (int k = NK - 1; k >= 0; k--) if (m_deb[k]) begin sel = k; valid = 1; end
    cur = model_spk();
    if (!valid) begin
      m_sounding = 0;
    end else if (!m_sounding) begin
      m_sounding = 1; m_note = sel; m_start = 1; m_n = 0;
    end else if (sel != m_note) begin
      m_note = sel; m_start = ~cur; m_n = 0;
    end else begin
      m_n++;
    end
    // A key flips once its last DB samples all disagree with the accepted level.
    for (int k = 0; k < NK; k++) begin
      m_hist[k] = {m_hist[k][DB-2:0], light[k]};
      if (m_hist[k] == {DB{~m_deb[k]}}) m_deb[k] = ~m_deb[k];
    end
  endtask

  task automatic step(input logic [NK-1:0] l, input logic r);
    light = l;
    rst   = r;
    @(posedge clk);
    model_edge();
    #1;
    step_no++;
    chk("speaker", int'(speaker), int'(model_spk()));
    chk("active", int'(active), int'(m_sounding));
    chk("note_idx", int'(note_idx), m_note);
  endtask

  task automatic hold(input logic [NK-1:0] l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0);
  endtask

  initial begin
    logic [NK-1:0] rl;
    int            len;
    m_deb = '0;
    for (int k = 0; k < NK; k++) m_hist[k] = '0;
    m_sounding = 0; m_note = 0; m_start = 0; m_n = 0;

    // Reset with all keys held, then release: active after the 4th edge.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
    chk("rst_active", int'(active), 0);
    chk("rst_speaker", int'(speaker), 0);
    hold(4'b1111, 3);
    chk("press_latency_idle", int'(active), 0);
    hold(4'b1111, 1);
    chk("press_latency_on", int'(active), 1);
    chk("press_note0", int'(note_idx), 0);
    hold(4'b0000, 6);

    // Single key tone and release.
    hold(4'b0100, 20);
    chk("key2_note", int'(note_idx), 2);
    hold(4'b0000, 5);
    chk("key2_release", int'(active), 0);

    // Short glitch is ignored.
    hold(4'b0010, 2);
    hold(4'b0000, 6);
    chk("glitch_quiet", int'(active), 0);

    // Higher-priority key interrupts and then hands back.
    hold(4'b1000, 12);
    hold(4'b1001, 14);
    chk("prio_note0", int'(note_idx), 0);
    hold(4'b1000, 20);
    chk("revert_note3", int'(note_idx), 3);
    hold(4'b0000, 6);

    // Simultaneous acceptance: lowest index.
    hold(4'b1010, 16);
    chk("simul_note1", int'(note_idx), 1);
    hold(4'b0000, 6);

    // Release and press accepted on the same edge.
    hold(4'b0001, 10);
    hold(4'b0010, 10);
    chk("handover_note1", int'(note_idx), 1);
    hold(4'b0000, 6);

    // Random key activity with occasional resets.
    for (int t = 0; t < 120; t++) begin
      rl  = NK'($urandom);
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 39) == 0) step(rl, 1'b1);
      hold(rl, len);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
